dom_and_xor_array: RTL and testbench

Pipelined, parametrised DOM masked AND-XOR layer. It computes y = x0 ^ (x1' & x2) bitwise on WIDTH lanes, with every operand in SHARES Boolean shares. x1' is x1 or its complement, chosen by INV_X1. The block sits in the masked datapath wherever a nonlinear chi/AND-XOR layer is needed, and replaces hand-instantiated single-bit two-share gadgets. It adds d-th order share counts, a valid/ready flow-control stage and a fresh-randomness handshake.

---
 rtl/dom_and_xor_array.sv | 104 ++++++++++
 tb/tb_dom_and_xor_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dom_and_xor_array.sv
`default_nettype none
// ============================================================================
// Module   : dom_and_xor_array
// Purpose  : Pipelined d-th order DOM masked AND-XOR layer, y = x0 ^ (x1' & x2)
// Revision : 1.0
// ============================================================================
module dom_and_xor_array #(
  parameter int WIDTH  = 8,
  parameter int SHARES = 2,
  parameter bit INV_X1 = 1'b1,
  localparam int RND_W = WIDTH * SHARES * (SHARES - 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SHARES*WIDTH-1:0]   x0,
  input  logic [SHARES*WIDTH-1:0]   x1,
  input  logic [SHARES*WIDTH-1:0]   x2,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [RND_W-1:0]          rnd,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic [SHARES*WIDTH-1:0]   y,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NTERMS = SHARES * SHARES;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Lexicographic index of the unordered share pair {a,b}, a != b.
  function automatic int pair_idx(input int a, input int b);
    int lo;
    int hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] x1_eff [SHARES];
  logic [WIDTH-1:0] term_d [NTERMS];
  logic [WIDTH-1:0] term_q [NTERMS];
  logic [WIDTH-1:0] comp   [SHARES];
  logic             fire;

  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) | out_ready;
  assign rnd_ready = in_valid & in_ready;
  assign fire      = in_valid & rnd_valid & in_ready;

  for (genvar s = 0; s < SHARES; s++) begin : g_x1
    if ((s == 0) && INV_X1) begin : g_inv
      assign x1_eff[s] = ~x1[s*WIDTH +: WIDTH];
    end else begin : g_pass
      assign x1_eff[s] = x1[s*WIDTH +: WIDTH];
    end
  end

  // Every term touches share i of x1 and share j of x2 only; mixing is deferred
  // until after the term registers so no glitch can combine two domains.
  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_inner
        assign term_d[i*SHARES+j] = (x1_eff[i] & x2[j*WIDTH +: WIDTH]) ^ x0[i*WIDTH +: WIDTH];
      end else begin : g_cross
        localparam int P = pair_idx(i, j);
        assign term_d[i*SHARES+j] = (x1_eff[i] & x2[j*WIDTH +: WIDTH]) ^ rnd[P*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      for (int k = 0; k < NTERMS; k++) begin
        term_q[k] <= '0;
      end
    end else if (fire) begin
      state_q <= FULL;
      for (int k = 0; k < NTERMS; k++) begin
        term_q[k] <= term_d[k];
      end
    end else if (out_ready) begin
      state_q <= EMPTY;
    end
  end

  for (genvar i = 0; i < SHARES; i++) begin : g_comp
    always_comb begin
      comp[i] = '0;
      for (int j = 0; j < SHARES; j++) begin
        comp[i] = comp[i] ^ term_q[i*SHARES+j];
      end
    end
    assign y[i*WIDTH +: WIDTH] = comp[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_dom_and_xor_array.sv
`default_nettype none
// Bench for dom_and_xor_array: directed vectors, lockstep S=4 run, and a
// scoreboarded S=3 instance under random handshakes.
module tb_dom_and_xor_array;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_shares(input int S, input int W, input bit inv,
      input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2, input logic [63:0] r);
    int pidx[4][4];
    int p;
    logic [31:0] m, a, b1, res;
    p = 0;
    m = (32'h1 << W) - 32'h1;
    for (int i = 0; i < S; i++)
      for (int j = i + 1; j < S; j++) begin
        pidx[i][j] = p;
        pidx[j][i] = p;
        p++;
      end
    res = '0;
    for (int i = 0; i < S; i++) begin
      a  = (x0 >> (i*W)) & m;
      b1 = (x1 >> (i*W)) & m;
      if (inv && i == 0) b1 = ~b1 & m;
      for (int j = 0; j < S; j++) begin
        a = a ^ (b1 & ((x2 >> (j*W)) & m));
        if (j != i) a = a ^ (32'(r >> (pidx[i][j]*W)) & m);
      end
      res = res | (a << (i*W));
    end
    return res;
  endfunction

  function automatic logic [31:0] unm(input logic [31:0] v, input int S, input int W);
    logic [31:0] u, m;
    m = (32'h1 << W) - 32'h1;
    u = '0;
    for (int s = 0; s < S; s++) u = u ^ ((v >> (s*W)) & m);
    return u;
  endfunction

  // ---------------- directed instances: W=4, S=2, INV 0 and 1
  logic [7:0] d_x0, d_x1, d_x2, a_y, b_y;
  logic [3:0] d_rnd;
  logic d_iv, d_rv, d_ordy, a_ir, a_rr, a_ov, b_ir, b_rr, b_ov;

  dom_and_xor_array #(.WIDTH(4), .SHARES(2), .INV_X1(1'b0)) u_a (
    .clk(clk), .rst(rst), .x0(d_x0), .x1(d_x1), .x2(d_x2),
    .in_valid(d_iv), .in_ready(a_ir), .rnd(d_rnd), .rnd_valid(d_rv), .rnd_ready(a_rr),
    .y(a_y), .out_valid(a_ov), .out_ready(d_ordy));

  dom_and_xor_array #(.WIDTH(4), .SHARES(2), .INV_X1(1'b1)) u_b (
    .clk(clk), .rst(rst), .x0(d_x0), .x1(d_x1), .x2(d_x2),
    .in_valid(d_iv), .in_ready(b_ir), .rnd(d_rnd), .rnd_valid(d_rv), .rnd_ready(b_rr),
    .y(b_y), .out_valid(b_ov), .out_ready(d_ordy));

  // ---------------- lockstep instance: W=5, S=4, INV=0
  logic [19:0] e_x0, e_x1, e_x2, e_y;
  logic [29:0] e_rnd;
  logic e_iv, e_ir, e_rr, e_ov;

  dom_and_xor_array #(.WIDTH(5), .SHARES(4), .INV_X1(1'b0)) u_e (
    .clk(clk), .rst(rst), .x0(e_x0), .x1(e_x1), .x2(e_x2),
    .in_valid(e_iv), .in_ready(e_ir), .rnd(e_rnd), .rnd_valid(e_iv), .rnd_ready(e_rr),
    .y(e_y), .out_valid(e_ov), .out_ready(1'b1));

  // ---------------- scoreboarded instance: W=8, S=3, INV=1
  logic [23:0] c_x0, c_x1, c_x2, c_y, c_rnd;
  logic c_iv, c_rv, c_ordy, c_ir, c_rr, c_ov, c_fire;

  dom_and_xor_array #(.WIDTH(8), .SHARES(3), .INV_X1(1'b1)) u_c (
    .clk(clk), .rst(rst), .x0(c_x0), .x1(c_x1), .x2(c_x2),
    .in_valid(c_iv), .in_ready(c_ir), .rnd(c_rnd), .rnd_valid(c_rv), .rnd_ready(c_rr),
    .y(c_y), .out_valid(c_ov), .out_ready(c_ordy));

  typedef struct packed {
    logic [23:0] y;
    logic [7:0]  u;
  } exp_t;
  exp_t sb_q[$];
  int   c_pops = 0;

  // Monitor: one time unit before each rising edge, a completed output transfer pops.
  always begin
    @(negedge clk);
    #4;
    if (!rst && c_ov && c_ordy) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 64'(c_y), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_shares", 64'(c_y), 64'(e.y));
        check("sb_unmasked", 64'(unm(32'(c_y), 3, 8)), 64'(e.u));
      end
      c_pops++;
    end
  end

  function automatic bit c_hold_x();
    return c_iv && !c_fire;
  endfunction

  function automatic bit c_hold_r();
    return c_rv && !c_fire;
  endfunction

  task automatic c_step(input bit iv, input bit rv, input bit ordy, input bit r);
    exp_t e;
    bit hx, hr;
    hx = c_hold_x();
    hr = c_hold_r();
    @(negedge clk);
    if (!hx) begin
      c_x0 = 24'($urandom()); c_x1 = 24'($urandom()); c_x2 = 24'($urandom());
    end
    if (!hr) c_rnd = 24'($urandom());
    c_iv = iv; c_rv = rv; c_ordy = ordy; rst = r;
    #1;
    c_fire = c_iv & c_rv & c_ir & !rst;
    if (c_fire) begin
      e.y = 24'(model_shares(3, 8, 1'b1, 32'(c_x0), 32'(c_x1), 32'(c_x2), 64'(c_rnd)));
      e.u = 8'(unm(32'(c_x0), 3, 8) ^ (~unm(32'(c_x1), 3, 8) & unm(32'(c_x2), 3, 8)));
      sb_q.push_back(e);
    end
  endtask

  task automatic c_drain();
    for (int k = 0; k < 10; k++) c_step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [19:0] e_exp, e_uexp;
    logic [23:0] y_snap;
    int p0, nfire, bubbles;

    rst = 1'b1;
    {d_x0, d_x1, d_x2, d_rnd, d_iv, d_rv, d_ordy} = '0;
    {e_x0, e_x1, e_x2, e_rnd, e_iv} = '0;
    {c_x0, c_x1, c_x2, c_rnd, c_iv, c_rv, c_ordy, c_fire} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(a_ov), 64'd0);
    check("reset_y", 64'(a_y), 64'd0);
    check("reset_in_ready", 64'(a_ir), 64'd1);

    // Directed: x0=(5,F), x1=(9,5), x2=(3,5), rnd=7 then rnd=0
    @(negedge clk);
    d_x0 = 8'hF5; d_x1 = 8'h59; d_x2 = 8'h53; d_rnd = 4'h7;
    d_iv = 1'b1; d_rv = 1'b1; d_ordy = 1'b1;
    @(negedge clk);
    d_rnd = 4'h0;
    check("dir_a_valid", 64'(a_ov), 64'd1);
    check("dir_a_y_r7", 64'(a_y), 64'hC2);
    check("dir_a_unmask_r7", 64'(a_y[3:0] ^ a_y[7:4]), 64'hE);
    check("dir_b_y_r7", 64'(b_y), 64'hC4);
    check("dir_b_unmask_r7", 64'(b_y[3:0] ^ b_y[7:4]), 64'h8);
    @(negedge clk);
    d_iv = 1'b0; d_rv = 1'b0;
    check("dir_a_y_r0", 64'(a_y), 64'hB5);
    check("dir_a_unmask_r0", 64'(a_y[3:0] ^ a_y[7:4]), 64'hE);
    check("dir_b_unmask_r0", 64'(b_y[3:0] ^ b_y[7:4]), 64'h8);
    @(negedge clk);
    check("dir_a_empty", 64'(a_ov), 64'd0);

    // Lockstep S=4 random stream, always ready
    for (int k = 0; k <= 1000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("s4_valid", 64'(e_ov), 64'd1);
        check("s4_shares", 64'(e_y), 64'(e_exp));
        check("s4_unmasked", 64'(unm(32'(e_y), 4, 5)), 64'(e_uexp));
      end
      if (k < 1000) begin
        e_x0 = 20'($urandom()); e_x1 = 20'($urandom()); e_x2 = 20'($urandom());
        e_rnd = 30'($urandom()); e_iv = 1'b1;
        e_exp  = 20'(model_shares(4, 5, 1'b0, 32'(e_x0), 32'(e_x1), 32'(e_x2), 64'(e_rnd)));
        e_uexp = 20'(unm(32'(e_x0), 4, 5) ^ (unm(32'(e_x1), 4, 5) & unm(32'(e_x2), 4, 5)));
      end else begin
        e_iv = 1'b0;
      end
    end

    // Random handshakes on the scoreboarded instance
    for (int k = 0; k < 3000; k++) begin
      c_step(c_hold_x() ? 1'b1 : ($urandom_range(0, 9) < 8),
             c_hold_r() ? 1'b1 : ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 9) < 7), 1'b0);
    end
    c_drain();
    check("rand_drained", 64'(sb_q.size()), 64'd0);

    // Backpressure: FULL with out_ready=0 for 5 cycles
    c_step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      c_step(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 0) y_snap = c_y;
      check("bp_valid", 64'(c_ov), 64'd1);
      check("bp_y_stable", 64'(c_y), 64'(y_snap));
      check("bp_in_ready", 64'(c_ir), 64'd0);
      check("bp_rnd_ready", 64'(c_rr), 64'd0);
    end
    c_step(1'b1, 1'b1, 1'b1, 1'b0);
    check("bp_release_fire", 64'(c_fire), 64'd1);
    p0 = c_pops;
    c_drain();
    check("bp_outputs", 64'(c_pops - p0), 64'd2);
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    // Randomness starvation: rnd_valid toggles 1010...
    p0 = c_pops;
    nfire = 0;
    for (int k = 0; k < 40; k++) begin
      c_step(1'b1, (k % 2 == 0), 1'b1, 1'b0);
      if (c_rr && c_rv) nfire++;
    end
    c_drain();
    check("starve_fires", 64'(nfire), 64'd20);
    check("starve_outputs", 64'(c_pops - p0), 64'(nfire));

    // Mid-stream reset discards the pending result
    repeat (3) c_step(1'b1, 1'b1, 1'b1, 1'b0);
    c_step(1'b0, 1'b0, 1'b0, 1'b0);
    check("prereset_valid", 64'(c_ov), 64'd1);
    c_step(1'b0, 1'b0, 1'b0, 1'b1);
    c_step(1'b0, 1'b0, 1'b0, 1'b1);
    sb_q.delete();
    c_step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_out_valid", 64'(c_ov), 64'd0);
    check("rst_y", 64'(c_y), 64'd0);
    check("rst_in_ready", 64'(c_ir), 64'd1);
    c_step(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_rnd_ready_follows", 64'(c_rr), 64'd1);
    c_step(1'b0, 1'b0, 1'b1, 1'b0);
    check("no_fire_without_rnd", 64'(c_ov), 64'd0);

    // Streaming: 100 words back to back
    p0 = c_pops;
    nfire = 0;
    bubbles = 0;
    for (int k = 0; k < 100; k++) begin
      c_step(1'b1, 1'b1, 1'b1, 1'b0);
      if (c_fire) nfire++;
      if (k > 0 && !c_ov) bubbles++;
    end
    c_drain();
    check("stream_fires", 64'(nfire), 64'd100);
    check("stream_bubbles", 64'(bubbles), 64'd0);
    check("stream_outputs", 64'(c_pops - p0), 64'd100);
    check("final_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
